// File: rtl/div_pkg.sv
// Shared types and width-generic constant helpers for the divider request front end.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10,
    RESP   = 2'b11
  } divfe_state_t;

  localparam int MAX_WIDTH = 64;

  // Callers cast the result down to their own width.
  function automatic logic [MAX_WIDTH-1:0] int_min(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '1;
    return v >> (MAX_WIDTH - width);
  endfunction

endpackage

// File: rtl/div_special_detect.sv
// Combinational detection of divide-by-zero and signed overflow, with the
// architecturally defined result for each case.
module div_special_detect
  import div_pkg::*;
#(
  parameter int parallelism = 32
) (
  input  div_op_t                op,
  input  logic [parallelism-1:0] a,
  input  logic [parallelism-1:0] b,
  output logic                   dz,
  output logic                   ovf,
  output logic                   is_special,
  output logic [parallelism-1:0] result
);

  localparam logic [parallelism-1:0] MIN_VAL = parallelism'(int_min(parallelism));
  localparam logic [parallelism-1:0] ONES    = parallelism'(all_ones(parallelism));

  logic is_rem;
  logic is_signed;

  assign is_rem     = (op == REM) || (op == REMU);
  assign is_signed  = (op == DIV) || (op == REM);
  assign dz         = (b == '0);
  // Zero divisor wins over overflow.
  assign ovf        = !dz && is_signed && (a == MIN_VAL) && (b == ONES);
  assign is_special = dz || ovf;

  always_comb begin
    result = '0;
    if (dz) begin
      result = is_rem ? a : ONES;
    end else if (!is_rem) begin
      result = a;
    end
  end

endmodule

// File: rtl/div_request_frontend.sv
// Valid/ready front end for the SRT divider. Optional result reuse is enabled
// by defining DIVFE_REUSE_EN.
module div_request_frontend
  import div_pkg::*;
#(
  parameter int parallelism = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [parallelism-1:0] req_a,
  input  logic [parallelism-1:0] req_b,
  output logic                   div_start,
  output logic                   div_usigned,
  output logic [parallelism-1:0] div_dividend,
  output logic [parallelism-1:0] div_divisor,
  input  logic                   div_done,
  input  logic [parallelism-1:0] div_quotient,
  input  logic [parallelism-1:0] div_reminder,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [parallelism-1:0] rsp_data,
  output logic                   rsp_dz,
  output logic                   rsp_ovf
);

  divfe_state_t state_reg, state_next;

  logic [1:0]             op_reg;
  logic [parallelism-1:0] a_reg, b_reg;
  logic [parallelism-1:0] data_reg, data_next;
  logic                   dz_reg, dz_next;
  logic                   ovf_reg, ovf_next;
  logic                   accept;

  logic                   sp_dz, sp_ovf, sp_special;
  logic [parallelism-1:0] sp_result;
  logic                   reuse_hit;
  logic [parallelism-1:0] reuse_result;

  div_special_detect #(
    .parallelism(parallelism)
  ) u_special (
    .op        (div_op_t'(req_op)),
    .a         (req_a),
    .b         (req_b),
    .dz        (sp_dz),
    .ovf       (sp_ovf),
    .is_special(sp_special),
    .result    (sp_result)
  );

`ifdef DIVFE_REUSE_EN
  logic                   reuse_valid_reg;
  logic                   reuse_usigned_reg;
  logic [parallelism-1:0] reuse_quo_reg, reuse_rem_reg;
  logic [parallelism-1:0] reuse_a_reg, reuse_b_reg;

  // Both halves of a completed division are kept so the sibling op is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reuse_valid_reg   <= 1'b0;
      reuse_usigned_reg <= 1'b0;
      reuse_quo_reg     <= '0;
      reuse_rem_reg     <= '0;
      reuse_a_reg       <= '0;
      reuse_b_reg       <= '0;
    end else if (state_reg == WAIT && div_done) begin
      reuse_valid_reg   <= 1'b1;
      reuse_usigned_reg <= op_reg[0];
      reuse_quo_reg     <= div_quotient;
      reuse_rem_reg     <= div_reminder;
      reuse_a_reg       <= a_reg;
      reuse_b_reg       <= b_reg;
    end
  end

  assign reuse_hit = reuse_valid_reg && (req_a == reuse_a_reg) && (req_b == reuse_b_reg)
                     && (req_op[0] == reuse_usigned_reg);
  assign reuse_result = req_op[1] ? reuse_rem_reg : reuse_quo_reg;
`else
  assign reuse_hit    = 1'b0;
  assign reuse_result = '0;
`endif

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    div_start  = 1'b0;
    rsp_valid  = 1'b0;
    data_next  = data_reg;
    dz_next    = dz_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: req_ready = 1'b1;
      LAUNCH: begin
        div_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          data_next  = op_reg[1] ? div_reminder : div_quotient;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    accept = req_valid && req_ready;
    // A new request overrides the handshake exit so RESP hands off without a gap.
    if (accept) begin
      if (sp_special) begin
        data_next  = sp_result;
        dz_next    = sp_dz;
        ovf_next   = sp_ovf;
        state_next = RESP;
      end else if (reuse_hit) begin
        data_next  = reuse_result;
        dz_next    = 1'b0;
        ovf_next   = 1'b0;
        state_next = RESP;
      end else begin
        dz_next    = 1'b0;
        ovf_next   = 1'b0;
        state_next = LAUNCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      data_reg <= '0;
      dz_reg   <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      data_reg <= data_next;
      dz_reg   <= dz_next;
      ovf_reg  <= ovf_next;
      if (accept) begin
        op_reg <= req_op;
        a_reg  <= req_a;
        b_reg  <= req_b;
      end
    end
  end

  assign div_usigned  = op_reg[0];
  assign div_dividend = a_reg;
  assign div_divisor  = b_reg;
  assign rsp_data     = data_reg;
  assign rsp_dz       = dz_reg;
  assign rsp_ovf      = ovf_reg;

endmodule

// File: tb/tb_div_request_frontend.sv
// Randomized bench for div_request_frontend with a fixed-latency divider model
// and a spec-level reference model. Honors DIVFE_REUSE_EN when defined.
module tb_div_request_frontend;

  localparam int W = 32;
  localparam int DIV_LAT = 34;
  localparam logic [W-1:0] MINV = 32'h8000_0000;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;
`ifdef DIVFE_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic         div_start, div_usigned;
  logic [W-1:0] div_dividend, div_divisor;
  logic         div_done = 1'b0;
  logic [W-1:0] div_quotient = '0, div_reminder = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;
  logic         rsp_dz, rsp_ovf;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_request_frontend #(.parallelism(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .div_start(div_start), .div_usigned(div_usigned), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_done(div_done), .div_quotient(div_quotient),
    .div_reminder(div_reminder), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf)
  );

  // ---------------- divider model: fixed latency, not reset by the front end
  int           start_count = 0;
  int           stab_viol = 0;
  int           pend_cnt = 0;
  logic         track = 1'b0;
  logic [W-1:0] lat_a = '0, lat_b = '0;
  logic         lat_u = 1'b0;

  function automatic void divide(input logic [W-1:0] a, input logic [W-1:0] b, input logic u,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
    int sa, sb;
    sa = a; sb = b;
    if (b == 0) begin q = ONES; r = a; end
    else if (u) begin q = a / b; r = a % b; end
    else if (a == MINV && b == ONES) begin q = a; r = '0; end
    else begin q = W'(sa / sb); r = W'(sa % sb); end
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] q, r;
    div_done = 1'b0;
    if (!rst_n) track = 1'b0;
    if (pend_cnt > 0) begin
      if (track && (div_dividend !== lat_a || div_divisor !== lat_b || div_usigned !== lat_u))
        stab_viol++;
      pend_cnt--;
      if (pend_cnt == 0) begin
        divide(lat_a, lat_b, lat_u, q, r);
        div_quotient = q;
        div_reminder = r;
        div_done = 1'b1;
        track = 1'b0;
      end
    end
    if (div_start === 1'b1) begin
      start_count++;
      pend_cnt = DIV_LAT;
      lat_a = div_dividend; lat_b = div_divisor; lat_u = div_usigned;
      track = 1'b1;
    end
  end

  // ---------------- reference model
  typedef struct packed {
    logic [W-1:0] data;
    logic         dz;
    logic         ovf;
    logic         special;
  } exp_t;

  logic         ru_valid = 1'b0;
  logic [W-1:0] ru_a = '0, ru_b = '0;
  logic         ru_u = 1'b0;

  function automatic exp_t ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa, sb;
    e = '0; sa = a; sb = b;
    if (b == 0) begin
      e.dz = 1'b1; e.special = 1'b1; e.data = op[1] ? a : ONES;
    end else if (!op[0] && a == MINV && b == ONES) begin
      e.ovf = 1'b1; e.special = 1'b1; e.data = op[1] ? '0 : a;
    end else if (op[0]) begin
      e.data = op[1] ? a % b : a / b;
    end else begin
      e.data = op[1] ? W'(sa % sb) : W'(sa / sb);
    end
    return e;
  endfunction

  function automatic bit is_hit(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return REUSE && ru_valid && a == ru_a && b == ru_b && op[0] == ru_u;
  endfunction

  task automatic collect(output bit found, output int k);
    found = 1'b0; k = 0;
    while (!found && k < 200) begin
      @(negedge clk);
      k++;
      if (rsp_valid === 1'b1) found = 1'b1;
    end
  endtask

  task automatic txn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    exp_t e;
    bit   hit, found;
    int   k, lat_e, s0, v0;
    e = ref_model(op, a, b);
    hit = !e.special && is_hit(op, a, b);
    lat_e = (e.special || hit) ? 1 : DIV_LAT + 2;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s req_ready: got %b expected 1", name, req_ready); end
    s0 = start_count; v0 = stab_viol;
    @(posedge clk); #1;
    req_valid = 1'b0;
    collect(found, k);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL %s timeout: rsp_valid got 0 expected 1", name); end
    n_checks++;
    if (k != lat_e) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, k, lat_e); end
    n_checks++;
    if (rsp_data !== e.data) begin n_fail++; $display("FAIL %s rsp_data: got %h expected %h", name, rsp_data, e.data); end
    n_checks++;
    if ({rsp_dz, rsp_ovf} !== {e.dz, e.ovf})
      begin n_fail++; $display("FAIL %s flags dz/ovf: got %b%b expected %b%b", name, rsp_dz, rsp_ovf, e.dz, e.ovf); end
    n_checks++;
    if (start_count - s0 != ((e.special || hit) ? 0 : 1))
      begin n_fail++; $display("FAIL %s div_start count: got %0d expected %0d", name, start_count - s0, (e.special || hit) ? 0 : 1); end
    n_checks++;
    if (stab_viol != v0) begin n_fail++; $display("FAIL %s operand stability: got %0d changes expected 0", name, stab_viol - v0); end
    if (found && !e.special && !hit) begin ru_valid = 1'b1; ru_a = a; ru_b = b; ru_u = op[0]; end
    $display("txn %s op=%0d a=%h b=%h data=%h dz=%0b ovf=%0b lat=%0d", name, op, a, b, rsp_data, rsp_dz, rsp_ovf, k);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    #2;
    n_checks++;
    if ({div_start, div_usigned, div_dividend, div_divisor, rsp_valid, rsp_data, rsp_dz, rsp_ovf} !== '0)
      begin n_fail++; $display("FAIL reset outputs: got nonzero (rsp_data=%h) expected 0", rsp_data); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
    $display("txn reset req_ready=%b rsp_valid=%b", req_ready, rsp_valid);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_normal();
    txn(2'b00, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    txn(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_neg7_2");
  endtask

  task automatic test_div_zero();
    txn(2'b01, 32'h1234_5678, 32'd0, "divu_by_zero");
    txn(2'b11, 32'h1234_5678, 32'd0, "remu_by_zero");
    txn(2'b00, MINV, 32'd0, "div_min_by_zero");
  endtask

  task automatic test_overflow();
    txn(2'b00, MINV, ONES, "div_overflow");
    txn(2'b10, MINV, ONES, "rem_overflow");
    txn(2'b01, MINV, ONES, "divu_no_overflow");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [1:0]   op;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = '0; end
        1: begin a = MINV; b = ONES; end
        2: begin a = $urandom_range(0, 60); b = $urandom_range(1, 9); end
        default: begin a = $urandom; b = $urandom; if (b == 0) b = 1; end
      endcase
      txn(op, a, b, "random");
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2;
    bit   found, hit;
    int   k, lat_e;
    e1 = ref_model(2'b01, 32'h1234_5678, 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'h1234_5678; req_b = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL backpressure rsp_valid cyc %0d: got %b expected 1", i, rsp_valid); end
      n_checks++;
      if (rsp_data !== e1.data) begin n_fail++; $display("FAIL backpressure rsp_data cyc %0d: got %h expected %h", i, rsp_data, e1.data); end
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure req_ready cyc %0d: got %b expected 0", i, req_ready); end
    end
    $display("txn backpressure held data=%h dz=%0b", rsp_data, rsp_dz);
    e2 = ref_model(2'b00, 32'd1000, 32'd13);
    hit = is_hit(2'b00, 32'd1000, 32'd13);
    lat_e = hit ? 1 : DIV_LAT + 2;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd1000; req_b = 32'd13;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL handoff req_ready: got %b expected 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    collect(found, k);
    n_checks++;
    if (!found || k != lat_e) begin n_fail++; $display("FAIL handoff latency: got %0d (found=%0b) expected %0d", k, found, lat_e); end
    n_checks++;
    if (rsp_data !== e2.data) begin n_fail++; $display("FAIL handoff rsp_data: got %h expected %h", rsp_data, e2.data); end
    if (found && !hit) begin ru_valid = 1'b1; ru_a = 32'd1000; ru_b = 32'd13; ru_u = 1'b0; end
    $display("txn back_to_back op=0 a=%h b=%h data=%h lat=%0d", 32'd1000, 32'd13, rsp_data, k);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    int s0, seen;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd5003; req_b = 32'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({div_start, div_usigned, div_dividend, div_divisor, rsp_valid, rsp_data, rsp_dz, rsp_ovf} !== '0)
      begin n_fail++; $display("FAIL midreset outputs: got nonzero (div_dividend=%h) expected 0", div_dividend); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset req_ready: got %b expected 1", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ru_valid = 1'b0;
    s0 = start_count; seen = 0;
    repeat (DIV_LAT + 10) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL late_done rsp_valid cycles: got %0d expected 0", seen); end
    n_checks++;
    if (start_count != s0) begin n_fail++; $display("FAIL late_done div_start: got %0d expected 0", start_count - s0); end
    $display("txn reset_mid_wait rsp_valid_cycles=%0d", seen);
    txn(2'b00, 32'd5003, 32'd11, "after_reset");
  endtask

  task automatic test_reuse();
    txn(2'b00, 32'd100, 32'd7, "reuse_div");
    txn(2'b10, 32'd100, 32'd7, "reuse_rem");
    txn(2'b10, 32'd100, 32'd8, "reuse_miss_rem");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_wait();
    test_reuse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
